jpeg_byte_stuffer: RTL and testbench
====================================

Name: jpeg_byte_stuffer

Overview:
Output-side stage of the JPEG entropy path. Takes the entropy-coded byte stream over a valid/ready handshake and emits it with JPEG byte stuffing: a 0x00 byte is inserted after every 0xFF data byte. Marker bytes, flagged by the producer, pass through unstuffed. The output register is loaded through the codebase's 2:1 8-bit byte mux, which selects between the incoming data byte and the stuffing byte.

Parameters:
COUNT_W, 24, width of the output byte and stuffed byte counters
ESC_BYTE, 8'hFF, data value that triggers stuffing
STUFF_BYTE, 8'h00, value inserted after ESC_BYTE

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  8  input byte
in_marker  in  1  in_data is part of a marker; suppresses stuffing
in_valid  in  1  input byte available
in_ready  out  1  stage accepts the input byte this cycle
out_data  out  8  output byte (registered)
out_valid  out  1  out_data valid (registered)
out_ready  in  1  downstream accepts out_data
byte_count  out  COUNT_W  bytes handed off at the output, wraps modulo 2^COUNT_W
stuff_count  out  COUNT_W  stuffing bytes handed off, wraps modulo 2^COUNT_W

Behaviour:
- Reset is asynchronous on rst_n low. Reset values: out_valid=0, out_data=0x00, byte_count=0, stuff_count=0, state=PASS. Reset taken mid-stream discards any held byte and any pending stuff.
- Handshakes: input accept = in_valid & in_ready. Output handoff = out_valid & out_ready.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- State PASS:
  - in_ready = !out_valid | out_ready.
  - On input accept, load out_data=in_data through the mux (code=0) and set out_valid=1.
  - If in_data==ESC_BYTE and in_marker=0, go to STUFF.
  - If there is no accept but a handoff occurs, clear out_valid.
- State STUFF (the ESC byte is held or about to be handed off):
  - in_ready=0.
  - On handoff, load out_data=STUFF_BYTE through the mux (code=1), keep out_valid=1, and return to PASS.
  - The stuffing byte is handed off under the normal PASS rules. The next input byte can be accepted in the same cycle the stuffing byte is handed off.
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 byte/cycle with out_ready=1. Each stuffed ESC byte costs exactly one input bubble cycle.
- Simultaneous events in PASS: accept and handoff in the same cycle replaces the register contents with no bubble.
- An ESC byte with in_marker=1 is not stuffed. A marker such as FF D9 passes through as exactly FF D9.
- Counters:
  - byte_count increments by 1 on every handoff, including stuffing bytes.
  - stuff_count increments on the handoff of each stuffing byte.
  - Both wrap to 0 after 2^COUNT_W-1 with no saturation and no flag.
- in_data and in_marker are ignored when in_valid=0.

Decomposition:
- Shared package: ESC_BYTE/STUFF_BYTE defaults, the MARKER_PREFIX constant 8'hFF, and the state encoding (PASS=1'b0, STUFF=1'b1).
- One sub-module: the existing mux_2x8bit instance.
  - x0 = in_data, x1 = STUFF_BYTE, code = (state==STUFF).
  - Its output drives the D input of out_data.
- Handshake logic, state register and counters are inline.

Test Plan:
- Reset mid-stream: pulse rst_n low while out_valid=1 holding 0xFF in STUFF. Outputs go 0 immediately, asynchronously. After release, the stream restarts cleanly with no stray 0x00.
- Plain stream: in_data 0x12,0x34,0x56 back-to-back with out_ready=1 -> out 0x12,0x34,0x56 on consecutive cycles, 1-cycle latency, byte_count=3, stuff_count=0.
- Stuffing: in 0xAB,0xFF,0xCD (marker=0), out_ready=1 -> out 0xAB,0xFF,0x00,0xCD. in_ready is low for exactly one cycle. byte_count=4, stuff_count=1.
- Marker bypass: in 0xFF,0xD9 with in_marker=1 -> out 0xFF,0xD9 with no 0x00 and no bubble. stuff_count unchanged.
- Backpressure: hold out_ready=0 for 5 cycles with 0xFF held -> out_data stays 0xFF and in_ready stays 0. After release, the bench sees 0xFF then 0x00. No byte is lost or duplicated.
- Counter wrap with COUNT_W=4: send 17 non-ESC bytes -> byte_count wraps from 15 to 0 and ends at 1.

Source files
------------

// File: rtl/jpeg_byte_stuffer_pkg.sv
// Purpose: shared constants and state encoding for the JPEG byte stuffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jpeg_byte_stuffer_pkg;

    localparam logic [7:0] ESC_BYTE_DEF   = 8'hFF;
    localparam logic [7:0] STUFF_BYTE_DEF = 8'h00;
    localparam logic [7:0] MARKER_PREFIX  = 8'hFF;

    // PASS: forwarding input bytes. STUFF: an ESC data byte is held and owes a stuffing byte.
    typedef enum logic {
        PASS  = 1'b0,
        STUFF = 1'b1
    } state_e;

endpackage

// File: rtl/jpeg_byte_stuffer_if.sv
// Purpose: byte-stream handshake bundle (input side and output side) for the stuffer.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the stage, out_ready from downstream.
interface jpeg_byte_stuffer_if;

    logic [7:0] in_data;
    logic       in_marker;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // Stage side: consumes the input stream, produces the output stream.
    modport slave (
        input  in_data, in_marker, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    // Producer/consumer side that surrounds the stage.
    modport master (
        output in_data, in_marker, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

endinterface

// File: rtl/jpeg_byte_stuffer_mux.sv
// Purpose: 2:1 8-bit byte mux (code=0 selects x0, code=1 selects x1).
// Latency: combinational.
// Backpressure: none.
module mux_2x8bit (
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic       code,
    output logic [7:0] y
);

    assign y = code ? x1 : x0;

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// Purpose: JPEG byte stuffing; inserts STUFF_BYTE after each non-marker ESC_BYTE.
// Latency: 1 cycle input accept to out_valid; one input bubble per stuffed byte.
// Backpressure: registered output held while out_ready=0; in_ready follows output slot.
module jpeg_byte_stuffer
    import jpeg_byte_stuffer_pkg::*;
#(
    parameter int         COUNT_W    = 24,
    parameter logic [7:0] ESC_BYTE   = ESC_BYTE_DEF,
    parameter logic [7:0] STUFF_BYTE = STUFF_BYTE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    jpeg_byte_stuffer_if.slave bus,
    output logic [COUNT_W-1:0] byte_count,
    output logic [COUNT_W-1:0] stuff_count
);

    state_e             state_q, state_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               stuff_held_q, stuff_held_d;
    logic [COUNT_W-1:0] byte_count_q, stuff_count_q;

    logic               in_ready;
    logic               accept;
    logic               handoff;
    logic               load;
    logic [7:0]         mux_y;

    assign in_ready = (state_q == PASS) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign handoff  = out_valid_q && bus.out_ready;

    // Byte source for the output register: the incoming byte in PASS, the stuffing byte in STUFF.
    mux_2x8bit u_mux (
        .x0   (bus.in_data),
        .x1   (STUFF_BYTE),
        .code (state_q == STUFF),
        .y    (mux_y)
    );

    // Next-state, output-register load and stuffing-byte tracking.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        stuff_held_d = stuff_held_q;
        load         = 1'b0;
        unique case (state_q)
            PASS: begin
                if (accept) begin
                    load         = 1'b1;
                    out_valid_d  = 1'b1;
                    stuff_held_d = 1'b0;
                    if (bus.in_data == ESC_BYTE && !bus.in_marker) begin
                        state_d = STUFF;
                    end
                end else if (handoff) begin
                    out_valid_d  = 1'b0;
                    stuff_held_d = 1'b0;
                end
            end
            STUFF: begin
                // ESC byte leaves; the stuffing byte takes its place with no gap.
                if (handoff) begin
                    load         = 1'b1;
                    out_valid_d  = 1'b1;
                    stuff_held_d = 1'b1;
                    state_d      = PASS;
                end
            end
            default: state_d = PASS;
        endcase
        out_data_d = load ? mux_y : out_data_q;
    end

    // State, output register and handoff counters; reset drops any held byte or pending stuff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PASS;
            out_data_q    <= 8'h00;
            out_valid_q   <= 1'b0;
            stuff_held_q  <= 1'b0;
            byte_count_q  <= '0;
            stuff_count_q <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            stuff_held_q <= stuff_held_d;
            if (handoff) begin
                byte_count_q <= byte_count_q + COUNT_W'(1);
                if (stuff_held_q) begin
                    stuff_count_q <= stuff_count_q + COUNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign byte_count    = byte_count_q;
    assign stuff_count   = stuff_count_q;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
module tb_jpeg_byte_stuffer;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] byte_count;
    logic [CW-1:0] stuff_count;
    int            n_tests;
    int            n_fail;

    jpeg_byte_stuffer_if bus ();

    jpeg_byte_stuffer #(.COUNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .byte_count  (byte_count),
        .stuff_count (stuff_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       m;
        logic       v;
        logic       ordy;
        logic       exp_ir;
        logic [7:0] exp_d;
        logic       exp_v;
        int         exp_bc;
        int         exp_sc;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       is_stuff;
    } item_t;

    vec_t  tbl[25];
    item_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_marker = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(logic [7:0] d, logic m, logic v, logic ordy, logic ir,
                                logic [7:0] ed, logic ev, int bc, int sc);
        vec_t r;
        r.d = d; r.m = m; r.v = v; r.ordy = ordy; r.exp_ir = ir;
        r.exp_d = ed; r.exp_v = ev; r.exp_bc = bc; r.exp_sc = sc;
        return r;
    endfunction

    initial begin
        int bc_m;
        int sc_m;
        logic ir_s, ov_s, or_s, acc, hof;
        logic [7:0] od_s;
        item_t it;

        n_tests = 0;
        n_fail  = 0;

        // Plain stream, stuffing, marker bypass, output stall on a held ESC, PASS stall.
        tbl[0]  = mk(8'h12, 0, 1, 1, 1, 8'h12, 1, 0, 0);
        tbl[1]  = mk(8'h34, 0, 1, 1, 1, 8'h34, 1, 1, 0);
        tbl[2]  = mk(8'h56, 0, 1, 1, 1, 8'h56, 1, 2, 0);
        tbl[3]  = mk(8'h00, 0, 0, 1, 1, 8'h56, 0, 3, 0);
        tbl[4]  = mk(8'hAB, 0, 1, 1, 1, 8'hAB, 1, 3, 0);
        tbl[5]  = mk(8'hFF, 0, 1, 1, 1, 8'hFF, 1, 4, 0);
        tbl[6]  = mk(8'hCD, 0, 1, 1, 0, 8'h00, 1, 5, 0);
        tbl[7]  = mk(8'hCD, 0, 1, 1, 1, 8'hCD, 1, 6, 1);
        tbl[8]  = mk(8'h00, 0, 0, 1, 1, 8'hCD, 0, 7, 1);
        tbl[9]  = mk(8'hFF, 1, 1, 1, 1, 8'hFF, 1, 7, 1);
        tbl[10] = mk(8'hD9, 1, 1, 1, 1, 8'hD9, 1, 8, 1);
        tbl[11] = mk(8'h00, 0, 0, 1, 1, 8'hD9, 0, 9, 1);
        tbl[12] = mk(8'hFF, 0, 1, 1, 1, 8'hFF, 1, 9, 1);
        for (int i = 13; i < 18; i++) tbl[i] = mk(8'h77, 0, 1, 0, 0, 8'hFF, 1, 9, 1);
        tbl[18] = mk(8'h77, 0, 1, 1, 0, 8'h00, 1, 10, 1);
        tbl[19] = mk(8'h77, 0, 1, 1, 1, 8'h77, 1, 11, 2);
        tbl[20] = mk(8'h00, 0, 0, 1, 1, 8'h77, 0, 12, 2);
        tbl[21] = mk(8'h88, 0, 1, 0, 1, 8'h88, 1, 12, 2);
        tbl[22] = mk(8'h99, 0, 1, 0, 0, 8'h88, 1, 12, 2);
        tbl[23] = mk(8'h99, 0, 1, 1, 1, 8'h99, 1, 13, 2);
        tbl[24] = mk(8'h00, 0, 0, 1, 1, 8'h99, 0, 14, 2);

        do_reset();
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_data", 32'(bus.out_data), 32'h00);
        chk("reset_byte_count", 32'(byte_count), 32'd0);
        chk("reset_stuff_count", 32'(stuff_count), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            bus.in_data   = tbl[i].d;
            bus.in_marker = tbl[i].m;
            bus.in_valid  = tbl[i].v;
            bus.out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_ir));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_v));
            chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].exp_d));
            chk($sformatf("vec%0d_byte_count", i), 32'(byte_count), 32'(tbl[i].exp_bc % 16));
            chk($sformatf("vec%0d_stuff_count", i), 32'(stuff_count), 32'(tbl[i].exp_sc % 16));
        end

        // Asynchronous reset while an ESC byte is stalled with its stuffing byte pending.
        @(negedge clk);
        bus.in_data = 8'hFF; bus.in_marker = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("midrst_pre_out_data", 32'(bus.out_data), 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_async_out_data", 32'(bus.out_data), 32'h00);
        chk("midrst_async_byte_count", 32'(byte_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data = 8'h42; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("midrst_restart_data", 32'(bus.out_data), 32'h42);
        chk("midrst_restart_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_stray_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_byte_count", 32'(byte_count), 32'd1);
        chk("midrst_stuff_count", 32'(stuff_count), 32'd0);

        // Counter wrap: 17 non-ESC bytes through a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus.in_data = 8'(i + 1); bus.in_marker = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            @(posedge clk); #1;
            if (i == 16) chk("wrap_at_16", 32'(byte_count), 32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("wrap_final", 32'(byte_count), 32'd1);

        // Randomized traffic against a queue model of the stuffed stream.
        do_reset();
        bc_m = 0;
        sc_m = 0;
        q.delete();
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            if (cyc < 400) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_data   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                bus.in_marker = ($urandom_range(0, 4) == 0);
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
            #1;
            ir_s = bus.in_ready;
            ov_s = bus.out_valid;
            od_s = bus.out_data;
            or_s = bus.out_ready;
            acc  = bus.in_valid && ir_s;
            hof  = ov_s && or_s;
            if (hof) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_byte", 32'(od_s), 32'h1FF);
                end else begin
                    it = q.pop_front();
                    chk("rand_out_data", 32'(od_s), 32'(it.d));
                    bc_m = (bc_m + 1) % 16;
                    if (it.is_stuff) sc_m = (sc_m + 1) % 16;
                end
            end
            if (acc) begin
                q.push_back('{d: bus.in_data, is_stuff: 1'b0});
                if (bus.in_data == 8'hFF && !bus.in_marker) q.push_back('{d: 8'h00, is_stuff: 1'b1});
            end
            @(posedge clk); #1;
            if (ov_s && !or_s) begin
                chk("rand_stall_valid", 32'(bus.out_valid), 32'd1);
                chk("rand_stall_data", 32'(bus.out_data), 32'(od_s));
            end
            chk("rand_byte_count", 32'(byte_count), 32'(bc_m));
            chk("rand_stuff_count", 32'(stuff_count), 32'(sc_m));
        end
        chk("rand_drained", 32'(q.size()), 32'd0);
        chk("rand_final_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
